univ_reg: RTL and testbench

//   Parametrised universal datapath register: load, shift, count and checkpoint on one clock.

---
 rtl/univ_reg_pkg.sv | 13 +
 rtl/univ_reg_next.sv | 63 ++++++
 rtl/univ_reg.sv | 71 +++++++
 tb/tb_univ_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - op-code encodings shared by univ_reg and its controlling FSMs
package univ_reg_pkg;

    localparam logic [2:0] OP_HOLD    = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_SHL     = 3'b010;
    localparam logic [2:0] OP_SHR     = 3'b011;
    localparam logic [2:0] OP_INC     = 3'b100;
    localparam logic [2:0] OP_DEC     = 3'b101;
    localparam logic [2:0] OP_SAVE    = 3'b110;
    localparam logic [2:0] OP_RESTORE = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// rtl/univ_reg_next.sv - combinational next-state for the universal register
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] shadow,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             cout,
    output logic [WIDTH-1:0] q_nxt,
    output logic [WIDTH-1:0] shadow_nxt,
    output logic             cout_nxt
);

    logic all_ones;
    logic is_zero;

    assign all_ones = &q;
    assign is_zero  = ~|q;

    always_comb begin
        q_nxt      = q;
        shadow_nxt = shadow;
        cout_nxt   = cout;
        unique case (op)
            OP_HOLD: ;
            OP_LOAD: begin
                q_nxt    = d;
                cout_nxt = 1'b0;
            end
            OP_SHL: begin
                q_nxt    = {q[WIDTH-2:0], sin};
                cout_nxt = q[WIDTH-1];
            end
            OP_SHR: begin
                q_nxt    = {sin, q[WIDTH-1:1]};
                cout_nxt = q[0];
            end
            OP_INC: begin
                // Saturating mode pins q at the boundary but still flags the overflow.
                q_nxt    = (SATURATE && all_ones) ? q : q + WIDTH'(1);
                cout_nxt = all_ones;
            end
            OP_DEC: begin
                q_nxt    = (SATURATE && is_zero) ? q : q - WIDTH'(1);
                cout_nxt = is_zero;
            end
            OP_SAVE: begin
                shadow_nxt = q;
            end
            OP_RESTORE: begin
                q_nxt    = shadow;
                cout_nxt = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// rtl/univ_reg.sv - universal datapath register: load, shift, inc/dec, save/restore
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] shadow_nxt;
    logic             cout_nxt;

    univ_reg_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next (
        .op         (op),
        .q          (q_q),
        .shadow     (shadow_q),
        .d          (d),
        .sin        (sin),
        .cout       (cout_q),
        .q_nxt      (q_nxt),
        .shadow_nxt (shadow_nxt),
        .cout_nxt   (cout_nxt)
    );

    always_comb begin
        q_d      = q_q;
        shadow_d = shadow_q;
        cout_d   = cout_q;
        if (en) begin
            q_d      = q_nxt;
            shadow_d = shadow_nxt;
            cout_d   = cout_nxt;
        end
    end

    // Reset overrides en/op, so an op issued in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= RST_VAL;
            shadow_q <= RST_VAL;
            cout_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            shadow_q <= shadow_d;
            cout_q   <= cout_d;
        end
    end

    assign q    = q_q;
    assign cout = cout_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// tb/tb_univ_reg.sv - directed self-checking bench for univ_reg (wrap, saturate, RST_VAL variants)
module tb_univ_reg;
    import univ_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] op  = OP_HOLD;
    logic [7:0] d   = 8'h00;
    logic       sin = 1'b0;

    logic [7:0] q_w, q_s, q_r;
    logic       cout_w, cout_s, cout_r;
    logic       zero_w, zero_s, zero_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(8), .RST_VAL(8'h00), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
        .q(q_w), .cout(cout_w), .zero(zero_w)
    );

    univ_reg #(.WIDTH(8), .RST_VAL(8'h00), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
        .q(q_s), .cout(cout_s), .zero(zero_s)
    );

    univ_reg #(.WIDTH(8), .RST_VAL(8'h80), .SATURATE(1'b0)) dut_rv (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
        .q(q_r), .cout(cout_r), .zero(zero_r)
    );

    task automatic step(input logic r, input logic e, input logic [2:0] o,
                        input logic [7:0] dv, input logic s);
        @(negedge clk);
        rst = r;
        en  = e;
        op  = o;
        d   = dv;
        sin = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, OP_LOAD, 8'hFF, 1'b0);
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b0 || zero_w !== 1'b1) begin
            errors++;
            $display("FAIL reset_wrap q=%h cout=%b zero=%b expected q=00 cout=0 zero=1", q_w, cout_w, zero_w);
        end
        checks++;
        if (q_r !== 8'h80 || cout_r !== 1'b0 || zero_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_rstval q=%h cout=%b zero=%b expected q=80 cout=0 zero=0", q_r, cout_r, zero_r);
        end
    endtask

    task automatic test_shift;
        step(1'b0, 1'b1, OP_LOAD, 8'hA5, 1'b0);
        checks++;
        if (q_w !== 8'hA5 || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL load q=%h cout=%b expected q=a5 cout=0", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_SHL, 8'h00, 1'b1);
        checks++;
        if (q_w !== 8'h4B || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL shl q=%h cout=%b expected q=4b cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_SHR, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h25 || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL shr q=%h cout=%b expected q=25 cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_SHR, 8'h00, 1'b1);
        checks++;
        if (q_w !== 8'h92 || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL shr_sin1 q=%h cout=%b expected q=92 cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_SHL, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h24 || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL shl_sin0 q=%h cout=%b expected q=24 cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_SHR, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h12 || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL shr_out0 q=%h cout=%b expected q=12 cout=0", q_w, cout_w);
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b1, OP_LOAD, 8'hFF, 1'b0);
        step(1'b0, 1'b1, OP_INC, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b1 || zero_w !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap q=%h cout=%b zero=%b expected q=00 cout=1 zero=1", q_w, cout_w, zero_w);
        end
        step(1'b0, 1'b1, OP_HOLD, 8'h55, 1'b1);
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL hold q=%h cout=%b expected q=00 cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_DEC, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'hFF || cout_w !== 1'b1 || zero_w !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap q=%h cout=%b zero=%b expected q=ff cout=1 zero=0", q_w, cout_w, zero_w);
        end
        step(1'b0, 1'b1, OP_DEC, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'hFE || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL dec_plain q=%h cout=%b expected q=fe cout=0", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_INC, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'hFF || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL inc_plain q=%h cout=%b expected q=ff cout=0", q_w, cout_w);
        end
    endtask

    task automatic test_saturate;
        step(1'b0, 1'b1, OP_LOAD, 8'hFE, 1'b0);
        step(1'b0, 1'b1, OP_INC, 8'h00, 1'b0);
        checks++;
        if (q_s !== 8'hFF || cout_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_inc1 q=%h cout=%b expected q=ff cout=0", q_s, cout_s);
        end
        step(1'b0, 1'b1, OP_INC, 8'h00, 1'b0);
        checks++;
        if (q_s !== 8'hFF || cout_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_inc2 q=%h cout=%b expected q=ff cout=1", q_s, cout_s);
        end
        step(1'b0, 1'b1, OP_LOAD, 8'h00, 1'b0);
        step(1'b0, 1'b1, OP_DEC, 8'h00, 1'b0);
        checks++;
        if (q_s !== 8'h00 || cout_s !== 1'b1 || zero_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_dec q=%h cout=%b zero=%b expected q=00 cout=1 zero=1", q_s, cout_s, zero_s);
        end
    endtask

    task automatic test_save_restore;
        step(1'b0, 1'b1, OP_LOAD, 8'h3C, 1'b0);
        step(1'b0, 1'b1, OP_SAVE, 8'h00, 1'b0);
        step(1'b0, 1'b1, OP_LOAD, 8'h11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, OP_RESTORE, 8'h77, 1'b1);
            checks++;
            if (q_w !== 8'h11 || cout_w !== 1'b0) begin
                errors++;
                $display("FAIL en0_hold cycle=%0d q=%h cout=%b expected q=11 cout=0", i, q_w, cout_w);
            end
        end
        step(1'b0, 1'b1, OP_RESTORE, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h3C || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL restore q=%h cout=%b expected q=3c cout=0", q_w, cout_w);
        end
        // SAVE must not disturb q or a pending cout
        step(1'b0, 1'b1, OP_LOAD, 8'hFF, 1'b0);
        step(1'b0, 1'b1, OP_INC, 8'h00, 1'b0);
        step(1'b0, 1'b1, OP_SAVE, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b1) begin
            errors++;
            $display("FAIL save_hold q=%h cout=%b expected q=00 cout=1", q_w, cout_w);
        end
        step(1'b0, 1'b1, OP_RESTORE, 8'h00, 1'b0);
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b0 || zero_w !== 1'b1) begin
            errors++;
            $display("FAIL save_restore q=%h cout=%b zero=%b expected q=00 cout=0 zero=1", q_w, cout_w, zero_w);
        end
    endtask

    task automatic test_rst_mid_op;
        step(1'b0, 1'b1, OP_LOAD, 8'h01, 1'b0);
        checks++;
        if (q_r !== 8'h01) begin
            errors++;
            $display("FAIL rv_load q=%h expected q=01", q_r);
        end
        step(1'b1, 1'b1, OP_INC, 8'h00, 1'b0);
        checks++;
        if (q_r !== 8'h80 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL rv_rst_inc q=%h cout=%b expected q=80 cout=0", q_r, cout_r);
        end
        step(1'b0, 1'b1, OP_RESTORE, 8'h00, 1'b0);
        checks++;
        if (q_r !== 8'h80 || cout_r !== 1'b0 || zero_r !== 1'b0) begin
            errors++;
            $display("FAIL rv_restore q=%h cout=%b zero=%b expected q=80 cout=0 zero=0", q_r, cout_r, zero_r);
        end
        checks++;
        if (q_w !== 8'h00 || cout_w !== 1'b0) begin
            errors++;
            $display("FAIL wrap_restore_after_rst q=%h cout=%b expected q=00 cout=0", q_w, cout_w);
        end
    endtask

    initial begin
        test_reset;
        test_shift;
        test_wrap;
        test_saturate;
        test_save_restore;
        test_rst_mid_op;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
